// File: rtl/pixel_proc_pkg.sv
// Shared types and constants for the two-pixel-per-clock RGB888 point-operation stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package pixel_proc_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_INV  = 3'd3;
    localparam logic [2:0] OP_THR  = 3'd4;
    localparam logic [2:0] OP_GRAY = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    // R+G+B never exceeds 765, so 10 bits hold it without overflow.
    function automatic logic [9:0] pix_sum(input pix_t p);
        return {2'b00, p.r} + {2'b00, p.g} + {2'b00, p.b};
    endfunction

endpackage

// File: rtl/pixel_op.sv
// Single-pixel point operation (pass/add/sub/invert/threshold, grayscale when PIXEL_PROC_GRAY_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
module pixel_op
    import pixel_proc_pkg::*;
#(
    parameter int VALUE     = 100,
    parameter int THRESHOLD = 90
) (
    input  pix_t       pix_i,
    input  logic [9:0] sum_i,
    input  logic [2:0] op_i,
    output pix_t       pix_o
);

    localparam logic [8:0] VAL9 = 9'(VALUE);
    localparam logic [9:0] THR3 = 10'(3 * THRESHOLD);

    // Saturating add: the 9th bit of the intermediate is the overflow flag.
    function automatic logic [7:0] sat_add(input logic [7:0] x);
        logic [8:0] t;
        t = {1'b0, x} + VAL9;
        return t[8] ? 8'hFF : 8'(t);
    endfunction

    // Saturating subtract: a negative signed result clamps to zero.
    function automatic logic [7:0] sat_sub(input logic [7:0] x);
        logic signed [9:0] t;
        t = $signed({2'b00, x}) - $signed({1'b0, VAL9});
        return (t < 0) ? 8'h00 : 8'(t);
    endfunction

    // Compare the sum against 3*THRESHOLD instead of dividing for the average.
    logic [7:0] thr_w;
    assign thr_w = (sum_i > THR3) ? 8'hFF : 8'h00;

`ifdef PIXEL_PROC_GRAY_EN
    // Weighted luma approximation (R + 2G + B) / 4, all terms in 10 bits.
    logic [9:0] gray_sum_w;
    logic [7:0] gray_w;
    assign gray_sum_w = {2'b00, pix_i.r} + {1'b0, pix_i.g, 1'b0} + {2'b00, pix_i.b};
    assign gray_w     = 8'(gray_sum_w >> 2);
`endif

    // Select the operation; unknown codes fall through to pass.
    always_comb begin
        pix_o = pix_i;
        case (op_i)
            OP_ADD: pix_o = '{r: sat_add(pix_i.r), g: sat_add(pix_i.g), b: sat_add(pix_i.b)};
            OP_SUB: pix_o = '{r: sat_sub(pix_i.r), g: sat_sub(pix_i.g), b: sat_sub(pix_i.b)};
            OP_INV: pix_o = '{r: ~pix_i.r, g: ~pix_i.g, b: ~pix_i.b};
            OP_THR: pix_o = '{r: thr_w, g: thr_w, b: thr_w};
`ifdef PIXEL_PROC_GRAY_EN
            OP_GRAY: pix_o = '{r: gray_w, g: gray_w, b: gray_w};
`endif
            default: pix_o = pix_i;
        endcase
    end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Frame-level RGB888 pixel-pair processing stage with geometry tracking; optional grayscale via PIXEL_PROC_GRAY_EN.
// Latency: fixed 2 cycles from accepted pair to hsync, one pair per cycle.
// Backpressure: none; pairs outside an active frame are dropped silently.
module pixel_proc_pipe
    import pixel_proc_pkg::*;
#(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int VALUE     = 100,
    parameter int THRESHOLD = 90
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       vsync_in,
    input  logic [2:0] op_sel,
    input  logic       hsync_in,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       hsync,
    output logic [7:0] DATA_WRITE_R0,
    output logic [7:0] DATA_WRITE_G0,
    output logic [7:0] DATA_WRITE_B0,
    output logic [7:0] DATA_WRITE_R1,
    output logic [7:0] DATA_WRITE_G1,
    output logic [7:0] DATA_WRITE_B1,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int COLS  = WIDTH / 2;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              drain_q, drain_d;
    logic              accept, last, start, err_d;

    // Stage 1 registers carry the op so a restarted frame cannot alter in-flight pairs.
    logic              s1_vld_q, s1_last_q;
    logic [2:0]        s1_op_q;
    pix_t              s1_p0_q, s1_p1_q;
    logic [9:0]        s1_sum0_q, s1_sum1_q;

    logic              out_vld_q, done_q, err_q;
    pix_t              out_p0_q, out_p1_q;

    pix_t              in_p0_w, in_p1_w, op_p0_w, op_p1_w;

    assign in_p0_w = '{r: DATA_R0, g: DATA_G0, b: DATA_B0};
    assign in_p1_w = '{r: DATA_R1, g: DATA_G1, b: DATA_B1};

    // Next-state, counters and acceptance; vsync restarts a frame from any state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vsync_in) start = 1'b1;
            end
            ST_ACTIVE: begin
                if (vsync_in) begin
                    start = 1'b1;
                end else if (hsync_in) begin
                    accept = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            last    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (vsync_in) begin
                    start = 1'b1;
                end else begin
                    drain_d = 1'b1;
                    if (drain_q) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_ACTIVE;
            op_d    = op_sel;
            col_d   = '0;
            row_d   = '0;
        end
    end

    assign err_d = (state_q == ST_ACTIVE) && vsync_in;

    // Control state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PASS;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Stage 1: capture accepted pair and precompute per-pixel sums.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_op_q   <= OP_PASS;
            s1_p0_q   <= '0;
            s1_p1_q   <= '0;
            s1_sum0_q <= '0;
            s1_sum1_q <= '0;
        end else begin
            s1_vld_q  <= accept;
            s1_last_q <= last;
            if (accept) begin
                s1_op_q   <= op_q;
                s1_p0_q   <= in_p0_w;
                s1_p1_q   <= in_p1_w;
                s1_sum0_q <= pix_sum(in_p0_w);
                s1_sum1_q <= pix_sum(in_p1_w);
            end
        end
    end

    pixel_op #(.VALUE(VALUE), .THRESHOLD(THRESHOLD)) u_op_even (
        .pix_i (s1_p0_q),
        .sum_i (s1_sum0_q),
        .op_i  (s1_op_q),
        .pix_o (op_p0_w)
    );

    pixel_op #(.VALUE(VALUE), .THRESHOLD(THRESHOLD)) u_op_odd (
        .pix_i (s1_p1_q),
        .sum_i (s1_sum1_q),
        .op_i  (s1_op_q),
        .pix_o (op_p1_w)
    );

    // Stage 2: register the processed pair; data holds while no pair is emitted.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
            out_p0_q  <= '0;
            out_p1_q  <= '0;
        end else begin
            out_vld_q <= s1_vld_q;
            done_q    <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                out_p0_q <= op_p0_w;
                out_p1_q <= op_p1_w;
            end
        end
    end

    assign hsync         = out_vld_q;
    assign frame_done    = done_q;
    assign frame_err     = err_q;
    assign busy          = (state_q != ST_IDLE);
    assign DATA_WRITE_R0 = out_p0_q.r;
    assign DATA_WRITE_G0 = out_p0_q.g;
    assign DATA_WRITE_B0 = out_p0_q.b;
    assign DATA_WRITE_R1 = out_p1_q.r;
    assign DATA_WRITE_G1 = out_p1_q.g;
    assign DATA_WRITE_B1 = out_p1_q.b;

endmodule

// File: doc/pixel_proc_pipe.md
Name: pixel_proc_pipe

Overview:
- Two-pixel-per-clock RGB888 processing stage between the BMP reader and the BMP writer.
- Takes even/odd pixel pairs tagged with a valid strobe and applies one frame-wide point operation: pass, brightness up/down, invert or threshold.
- Emits the result with a strobe in exactly the form the writer consumes: hsync plus R0/G0/B0 and R1/G1/B1.
- Tracks frame geometry and flags completion and protocol errors.

Parameters:
- WIDTH, 768, image width in pixels; must be even.
- HEIGHT, 512, image height in lines.
- VALUE, 100, brightness offset, 0..255.
- THRESHOLD, 90, threshold level on the per-pixel average, 0..255.

Ports:
- HCLK  in  1  clock; all logic on posedge.
- HRESET  in  1  reset, synchronous, active-high.
- vsync_in  in  1  one-cycle frame-start pulse from the reader.
- op_sel  in  3  operation code; sampled only on an accepted vsync_in.
- hsync_in  in  1  input pair valid.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- hsync  out  1  output pair valid.
- DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0  out  8 each  processed even pixel.
- DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1  out  8 each  processed odd pixel.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse, aligned with the last output pair.
- frame_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, pipeline valid bits cleared.
- Reset takes effect on the next edge even mid-frame: in-flight pairs are dropped and hsync is 0 from the following cycle.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on vsync_in: latch op_sel, clear col/row counters.
  - ACTIVE -> DONE when the pair at col=WIDTH/2-1, row=HEIGHT-1 is accepted.
  - DONE -> IDLE after 2 cycles, once the pipeline has drained.
- Acceptance: a pair is accepted only when hsync_in=1 in ACTIVE.
  - hsync_in in IDLE or DONE is ignored: no output, no counting.
- Counters: col counts 0..WIDTH/2-1, then wraps to 0 and increments row; row counts 0..HEIGHT-1.
- Latency: fixed 2 cycles from an accepted pair to hsync=1 with its data.
  - Stage 1 registers inputs plus per-pixel sum R+G+B, 10 bits.
  - Stage 2 applies the operation.
  - Back-to-back pairs every cycle, no bubbles; order preserved.
- Operations, applied per channel unless stated:
  - 0 pass.
  - 1 add: min(x+VALUE, 255), 9-bit intermediate.
  - 2 sub: max(x-VALUE, 0), signed compare.
  - 3 invert: 255-x.
  - 4 threshold, per pixel: if sum > 3*THRESHOLD all three channels = 255, else 0. No divider.
  - 5..7 behave as pass, unless the optional feature below is enabled.
- frame_done: pulses with hsync for the final pair; busy drops the cycle after.
- frame_err cases:
  - vsync_in in ACTIVE: pulse frame_err; restart the frame by re-latching op_sel and clearing counters. Pairs already in the pipeline still drain out.
  - vsync_in in DONE: accepted as a new frame start, no error.
  - vsync_in and hsync_in in the same IDLE cycle: start the frame; that pair is not accepted.
- When hsync=0, data outputs hold their last value.

Optional Feature:
- Macro PIXEL_PROC_GRAY_EN.
- When defined, op 5 = grayscale: all channels = (R + 2G + B) >> 2, computed in 10 bits from the stage-1 registers.
- When undefined, op 5 is pass and no grayscale logic is synthesized.

Decomposition:
- Package pixel_proc_pkg holds:
  - op-code localparams OP_PASS=0, OP_ADD=1, OP_SUB=2, OP_INV=3, OP_THR=4, OP_GRAY=5;
  - FSM state encoding;
  - the pixel-triple struct typedef.
- Sub-module pixel_op: combinational single-pixel operation with inputs R, G, B, sum and op, outputs R, G, B. Instantiate twice, for the even and odd pixel. The top keeps the FSM, counters and pipeline registers.

Test Plan (WIDTH=8, HEIGHT=2, VALUE=100, THRESHOLD=90):
- Op 1: vsync, op=1, then pairs (200,10,0)/(155,155,155) -> two cycles later (255,110,100)/(255,255,255) with hsync=1.
- Op 4: vsync, op=4, pairs with sums 271 and 270 -> even pixel all 255, odd pixel all 0.
- Full frame, op 3: vsync, op=3, 8 consecutive pairs -> 8 outputs, each 255-x; frame_done coincides with the 8th; busy=0 on the next cycle; a 9th hsync_in produces no output.
- Mid-frame restart: vsync after 3 pairs -> frame_err pulse; those 3 pairs still emerge; the next 8 pairs complete the frame with frame_done.
- Reset mid-frame: HRESET=1 for one cycle with 2 pairs in flight -> hsync=0 afterwards; all outputs 0; later hsync_in without vsync is ignored.
- With PIXEL_PROC_GRAY_EN: op=5, pixel (100,50,10) -> (52,52,52). Without the macro: same stimulus -> (100,50,10).
